// File: rtl/guess_submitter_pkg.sv
// Shared definitions for the guessing-game front end: submitter FSM states,
// default code geometry and a small saturating-counter helper.
package guess_submitter_pkg;

  localparam int PEGS_DEF    = 4;
  localparam int COLOR_W_DEF = 2;
  localparam int GUESS_NUM_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARMED      = 3'd1,
    ST_SUBMIT     = 3'd2,
    ST_WAIT_SCORE = 3'd3,
    ST_WON        = 3'd4,
    ST_LOST       = 3'd5
  } state_e;

  // Increment that stops at lim, so the guess count can never wrap.
  function automatic logic [GUESS_NUM_W-1:0] sat_inc(
    input logic [GUESS_NUM_W-1:0] v,
    input logic [GUESS_NUM_W-1:0] lim
  );
    logic [GUESS_NUM_W-1:0] r;
    r = v;
    if (v < lim) r = v + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/guess_submitter_key_sync.sv
// Two-flop synchronizer for the raw active-low submit key. The flops
// reset to the released level so a held key after reset is seen as a
// fresh press. press_o is active-high.
module key_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;

  // Resample the asynchronous key twice before anything downstream uses it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign press_o = ~sync2_q;

endmodule

// File: rtl/guess_submitter.sv
// Guess submitter: turns one press-release of the submit key into exactly
// one accepted guess, latches the switch code, counts guesses and tracks
// the game outcome reported by the scorer.
module guess_submitter
  import guess_submitter_pkg::*;
#(
  parameter int MAX_GUESSES = 10,
  parameter int PEGS        = PEGS_DEF,
  parameter int COLOR_W     = COLOR_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     key_n,
  input  logic [PEGS*COLOR_W-1:0]  sw_code,
  input  logic                     score_valid,
  input  logic                     score_win,
  output logic                     guess_pulse,
  output logic [PEGS*COLOR_W-1:0]  guess_code,
  output logic [GUESS_NUM_W-1:0]   guess_num,
  output logic                     busy,
  output logic                     won,
  output logic                     lost
);

  localparam int                     CODE_W  = PEGS * COLOR_W;
  localparam logic [GUESS_NUM_W-1:0] MAX_NUM = GUESS_NUM_W'(MAX_GUESSES);

  logic                   press;
  state_e                 state_q;
  logic [CODE_W-1:0]      code_q;
  logic [GUESS_NUM_W-1:0] num_q;
  logic                   pulse_q;

  key_sync u_key_sync (
    .clk_i   (clk),
    .rst_i   (reset),
    .key_n_i (key_n),
    .press_o (press)
  );

  // Submit FSM with guess capture, guess pulse and guess counter.
  // The pulse is raised on the same edge that enters SUBMIT, so it is
  // high for exactly the single SUBMIT cycle; the count advances as
  // SUBMIT is left, matching an external counter fed by the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      num_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (press) state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          // Only the release edge submits, so holding the key cannot
          // produce repeated guesses.
          if (!press) begin
            state_q <= ST_SUBMIT;
            code_q  <= sw_code;
            pulse_q <= 1'b1;
          end
        end
        ST_SUBMIT: begin
          num_q   <= sat_inc(num_q, MAX_NUM);
          state_q <= ST_WAIT_SCORE;
        end
        ST_WAIT_SCORE: begin
          // A win outranks running out of guesses.
          if (score_valid) begin
            if (score_win)             state_q <= ST_WON;
            else if (num_q >= MAX_NUM) state_q <= ST_LOST;
            else                       state_q <= ST_IDLE;
          end
        end
        ST_WON, ST_LOST: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign guess_pulse = pulse_q;
  assign guess_code  = code_q;
  assign guess_num   = num_q;
  assign busy        = (state_q == ST_SUBMIT) || (state_q == ST_WAIT_SCORE);
  assign won         = (state_q == ST_WON);
  assign lost        = (state_q == ST_LOST);

endmodule

// File: tb/tb_guess_submitter.sv
// Directed bench for guess_submitter with hand-computed expectations.
module tb_guess_submitter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_n = 1'b1;
  logic [7:0] sw_code = 8'h00;
  logic       score_valid = 1'b0;
  logic       score_win = 1'b0;
  logic       guess_pulse;
  logic [7:0] guess_code;
  logic [7:0] guess_num;
  logic       busy;
  logic       won;
  logic       lost;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  int consec_cnt = 0;
  logic prev_pulse = 1'b0;
  int base;

  guess_submitter #(.MAX_GUESSES(10), .PEGS(4), .COLOR_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_n       (key_n),
    .sw_code     (sw_code),
    .score_valid (score_valid),
    .score_win   (score_win),
    .guess_pulse (guess_pulse),
    .guess_code  (guess_code),
    .guess_num   (guess_num),
    .busy        (busy),
    .won         (won),
    .lost        (lost)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping, sampled on the inactive edge.
  always @(negedge clk) begin
    if (guess_pulse) pulse_cnt <= pulse_cnt + 1;
    if (guess_pulse && prev_pulse) consec_cnt <= consec_cnt + 1;
    prev_pulse <= guess_pulse;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press for hold cycles, release, and wait until WAIT_SCORE.
  task automatic press_release(input logic [7:0] code, input int hold);
    sw_code = code;
    key_n = 1'b0;
    tick(hold);
    key_n = 1'b1;
    tick(5);
  endtask

  task automatic score(input logic win);
    score_valid = 1'b1;
    score_win = win;
    tick(1);
    score_valid = 1'b0;
    score_win = 1'b0;
    tick(2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key_n = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_won", won, 0);
    chk("rst_lost", lost, 0);
    chk("rst_num", guess_num, 0);
    chk("rst_code", guess_code, 0);
    chk("rst_pulse", guess_pulse, 0);
    reset = 1'b0;
    tick(2);

    // Basic guess
    base = pulse_cnt;
    press_release(8'hE4, 5);
    chk("g1_pulses", pulse_cnt - base, 1);
    chk("g1_code", guess_code, 8'hE4);
    chk("g1_num", guess_num, 1);
    chk("g1_busy", busy, 1);

    // Key activity during WAIT_SCORE is ignored
    base = pulse_cnt;
    key_n = 1'b0;
    tick(6);
    key_n = 1'b1;
    tick(6);
    chk("wait_key_pulses", pulse_cnt - base, 0);
    chk("wait_key_busy", busy, 1);
    chk("wait_key_num", guess_num, 1);
    score(1'b0);
    chk("to_idle_busy", busy, 0);
    // Spurious score in IDLE is ignored
    score(1'b1);
    chk("idle_score_won", won, 0);
    chk("idle_score_busy", busy, 0);
    chk("idle_score_pulses", pulse_cnt - base, 0);
    press_release(8'h1B, 4);
    chk("g2_num", guess_num, 2);
    chk("g2_code", guess_code, 8'h1B);

    // Reset in the cycle after SUBMIT
    do_reset();
    sw_code = 8'h3C;
    key_n = 1'b0;
    tick(5);
    key_n = 1'b1;
    tick(3);
    chk("submit_pulse", guess_pulse, 1);
    tick(1);
    chk("post_submit_pulse", guess_pulse, 0);
    chk("post_submit_busy", busy, 1);
    reset = 1'b1;
    tick(1);
    chk("midrst_num", guess_num, 0);
    chk("midrst_code", guess_code, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pulse", guess_pulse, 0);
    reset = 1'b0;
    tick(2);

    // Long hold with toggling switches
    base = pulse_cnt;
    key_n = 1'b0;
    for (int i = 0; i < 50; i++) begin
      sw_code = 8'(i * 37);
      tick(1);
      if (i == 40) chk("hold_no_pulse", pulse_cnt - base, 0);
    end
    sw_code = 8'h5A;
    key_n = 1'b1;
    tick(5);
    chk("hold_pulses", pulse_cnt - base, 1);
    chk("hold_code", guess_code, 8'h5A);
    sw_code = 8'hFF;
    tick(2);
    chk("code_stable", guess_code, 8'h5A);
    score(1'b0);

    // Ten losing guesses
    do_reset();
    base = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      press_release(8'(i), 4);
      score(1'b0);
      if (i == 8) begin
        chk("nine_lost", lost, 0);
        chk("nine_num", guess_num, 9);
      end
    end
    chk("ten_num", guess_num, 10);
    chk("ten_lost", lost, 1);
    chk("ten_busy", busy, 0);
    chk("ten_pulses", pulse_cnt - base, 10);
    base = pulse_cnt;
    press_release(8'hAA, 4);
    score(1'b1);
    chk("lost_pulses", pulse_cnt - base, 0);
    chk("lost_num", guess_num, 10);
    chk("lost_hold", lost, 1);
    chk("lost_won", won, 0);

    // Win on the third guess
    do_reset();
    press_release(8'h11, 4);
    score(1'b0);
    press_release(8'h22, 4);
    score(1'b0);
    press_release(8'h33, 4);
    score(1'b1);
    chk("win3_won", won, 1);
    chk("win3_num", guess_num, 3);
    chk("win3_code", guess_code, 8'h33);
    base = pulse_cnt;
    score(1'b0);
    press_release(8'h44, 4);
    chk("win3_ignore_pulses", pulse_cnt - base, 0);
    chk("win3_hold_won", won, 1);
    chk("win3_hold_lost", lost, 0);
    chk("win3_hold_num", guess_num, 3);
    chk("win3_hold_code", guess_code, 8'h33);

    // Win on the last allowed guess beats the limit
    do_reset();
    for (int i = 0; i < 9; i++) begin
      press_release(8'(i + 16), 4);
      score(1'b0);
    end
    press_release(8'h99, 4);
    score(1'b1);
    chk("win10_won", won, 1);
    chk("win10_lost", lost, 0);
    chk("win10_num", guess_num, 10);

    // Key held through reset release counts as a new press
    reset = 1'b1;
    key_n = 1'b0;
    sw_code = 8'h77;
    tick(3);
    base = pulse_cnt;
    reset = 1'b0;
    tick(5);
    chk("held_rst_no_pulse", pulse_cnt - base, 0);
    key_n = 1'b1;
    tick(5);
    chk("held_rst_pulses", pulse_cnt - base, 1);
    chk("held_rst_num", guess_num, 1);
    chk("held_rst_code", guess_code, 8'h77);

    chk("no_back_to_back_pulse", consec_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
